// File: rtl/ram_reader_pkg.sv
// Shared types and build-time constants for the RAM burst reader.
// Define RAM_READER_LAT2_EN for a RAM with an extra output register (RD_LAT=2, BUF_DEPTH=3).
package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

`ifdef RAM_READER_LAT2_EN
    localparam int RD_LAT    = 2;
    localparam int BUF_DEPTH = 3;
`else
    localparam int RD_LAT    = 1;
    localparam int BUF_DEPTH = 2;
`endif

    // Bits needed to hold a count in 0..n.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// Control, RAM read-port and output-stream signals of the RAM burst reader.
interface ram_burst_reader_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9
);
    logic                  START;
    logic [ADDR_WIDTH-1:0] START_ADDR;
    logic [ADDR_WIDTH:0]   LEN;
    logic                  BUSY;
    logic                  DONE;
    logic                  RAM_RE;
    logic [ADDR_WIDTH-1:0] RAM_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DOUT;
    logic                  M_VALID;
    logic                  M_READY;
    logic [DATA_WIDTH-1:0] M_DATA;
    logic                  M_LAST;

    modport master (
        input  START, START_ADDR, LEN, RAM_DOUT, M_READY,
        output BUSY, DONE, RAM_RE, RAM_ADDR, M_VALID, M_DATA, M_LAST
    );

    modport slave (
        output START, START_ADDR, LEN, RAM_DOUT, M_READY,
        input  BUSY, DONE, RAM_RE, RAM_ADDR, M_VALID, M_DATA, M_LAST
    );
endinterface

// File: rtl/ram_reader_skid_fifo.sv
// Small register FIFO of {last, data} holding RAM words until the stream consumer takes them.
module ram_reader_skid_fifo
    import ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH      = BUF_DEPTH,
    parameter int OCC_W      = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [OCC_W-1:0]      occ
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_last [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is cleared too so the stream data output reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    assign out_valid = (occ != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_last  = out_valid & mem_last[rd_ptr];

endmodule

// File: rtl/ram_burst_reader.sv
// Issues LEN sequential RAM reads and streams the words out with credit-based backpressure.
// Build option RAM_READER_LAT2_EN (see ram_reader_pkg) selects the two-cycle RAM read latency.
module ram_burst_reader
    import ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9
) (
    input  logic            CLK,
    input  logic            RST,
    ram_burst_reader_if.master bus
);
    localparam int OCC_W  = cnt_w(BUF_DEPTH);
    localparam int INF_W  = cnt_w(RD_LAT);
    localparam int CRED_W = cnt_w(BUF_DEPTH) + 2;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH:0]     remaining;
    logic                    busy;
    logic                    done;

    logic [RD_LAT-1:0]       rd_vld_p;
    logic [RD_LAT-1:0]       rd_last_p;
    logic [INF_W-1:0]        inflight;
    logic signed [CRED_W-1:0] credit;
    logic                    credit_ok;
    logic                    re;
    logic                    last_tag;
    logic                    pop;

    logic [OCC_W-1:0]        occ;
    logic                    fifo_valid;
    logic                    fifo_last;
    logic [DATA_WIDTH-1:0]   fifo_data;

    assign pop      = fifo_valid & bus.M_READY;
    assign last_tag = (remaining == (ADDR_WIDTH + 1)'(1));

    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            inflight = inflight + INF_W'(rd_vld_p[k]);
        end
    end

    // A read issued now lands in the buffer RD_LAT cycles later; the current pop frees a slot.
    always_comb begin
        credit = CRED_W'(BUF_DEPTH) - CRED_W'(occ) - CRED_W'(inflight) + CRED_W'(pop);
    end

    assign credit_ok = !credit[CRED_W-1] && (credit != '0);
    assign re        = (state == ISSUE) && credit_ok;

    // RAM return pipe: p0 is the cycle after RE, p[RD_LAT-1] is when RAM_DOUT holds the word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld_p  <= '0;
            rd_last_p <= '0;
        end else begin
            rd_vld_p[0]  <= re;
            rd_last_p[0] <= re & last_tag;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld_p[k]  <= rd_vld_p[k-1];
                rd_last_p[k] <= rd_last_p[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        if (bus.LEN != '0) begin
                            addr      <= bus.START_ADDR;
                            remaining <= bus.LEN;
                            busy      <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (re) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (last_tag) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (inflight == '0 && pop && fifo_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_reader_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .OCC_W      (OCC_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (rd_vld_p[RD_LAT-1]),
        .push_data (bus.RAM_DOUT),
        .push_last (rd_last_p[RD_LAT-1]),
        .pop       (pop),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .out_last  (fifo_last),
        .occ       (occ)
    );

    assign bus.BUSY     = busy;
    assign bus.DONE     = done;
    assign bus.RAM_RE   = re;
    assign bus.RAM_ADDR = addr;
    assign bus.M_VALID  = fifo_valid;
    assign bus.M_DATA   = fifo_data;
    assign bus.M_LAST   = fifo_last;

endmodule
